// File: rtl/mc_control_fsm.sv
// Multicycle MIPS main controller: Moore FSM sequencing fetch/decode/execute/memory/write-back.
// Optional bne support is enabled by defining MC_CTRL_BNE_EN.
module mc_control_fsm #(
  parameter int             OPW      = 6,
  parameter logic [OPW-1:0] OP_RTYPE = OPW'(0),
  parameter logic [OPW-1:0] OP_LW    = OPW'(35),
  parameter logic [OPW-1:0] OP_SW    = OPW'(43),
  parameter logic [OPW-1:0] OP_ADDI  = OPW'(8),
  parameter logic [OPW-1:0] OP_BEQ   = OPW'(4),
  parameter logic [OPW-1:0] OP_J     = OPW'(2),
  parameter logic [OPW-1:0] OP_BNE   = OPW'(5)
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic [OPW-1:0] Opcode,
  input  logic           MemReady,
  output logic           IRWE,
  output logic           PCWE,
  output logic           Branch,
  output logic           IorD,
  output logic           MtoRFSel,
  output logic           DMWE,
  output logic           RFWE,
  output logic           RFDSel,
  output logic           ALUIn1Sel,
  output logic [1:0]     ALUIn2Sel,
  output logic [1:0]     ALUOp,
  output logic [1:0]     PCSrc,
  output logic           BranchNE,
  output logic           Illegal,
  output logic [3:0]     State
);

`ifdef MC_CTRL_BNE_EN
  localparam logic BNE_EN = 1'b1;
`else
  localparam logic BNE_EN = 1'b0;
`endif

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11,
    S_TRAP   = 4'd12
  } state_e;

  typedef struct packed {
    logic       fetch;
    logic       pcwe;
    logic       branch;
    logic       iord;
    logic       mtorf;
    logic       dmwe;
    logic       rfwe;
    logic       rfdsel;
    logic       alu1;
    logic [1:0] alu2;
    logic [1:0] aluop;
    logic [1:0] pcsrc;
    logic       bne;
    logic       illegal;
  } ctl_t;

  state_e         state_q, state_d;
  logic [OPW-1:0] op_q, op_d;
  ctl_t           ctl_q;
  logic           ne_d;

  // Moore output table; decoded from the next state so the outputs come straight from flops.
  function automatic ctl_t decode_ctl(input state_e s, input logic ne);
    ctl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.fetch = 1'b1;
        c.alu2  = 2'b01;
      end
      S_DECODE: c.alu2 = 2'b10;
      S_MEMADR: begin
        c.alu1 = 1'b1;
        c.alu2 = 2'b10;
      end
      S_MEMRD:  c.iord = 1'b1;
      S_MEMWB: begin
        c.rfwe  = 1'b1;
        c.mtorf = 1'b1;
      end
      S_MEMWR: begin
        c.iord = 1'b1;
        c.dmwe = 1'b1;
      end
      S_EXEC: begin
        c.alu1  = 1'b1;
        c.aluop = 2'b11;
      end
      S_ALUWB: begin
        c.rfwe   = 1'b1;
        c.rfdsel = 1'b1;
      end
      S_BRANCH: begin
        c.alu1   = 1'b1;
        c.aluop  = 2'b01;
        c.branch = 1'b1;
        c.pcsrc  = 2'b01;
        c.bne    = ne;
      end
      S_ADDIEX: begin
        c.alu1 = 1'b1;
        c.alu2 = 2'b10;
      end
      S_ADDIWB: c.rfwe = 1'b1;
      S_JUMP: begin
        c.pcwe  = 1'b1;
        c.pcsrc = 2'b10;
      end
      S_TRAP:   c.illegal = 1'b1;
      default:  c = '0;
    endcase
    return c;
  endfunction

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    case (state_q)
      S_FETCH:  if (MemReady) state_d = S_DECODE;
      S_DECODE: begin
        op_d = Opcode;
        if (Opcode == OP_LW || Opcode == OP_SW) state_d = S_MEMADR;
        else if (Opcode == OP_RTYPE)            state_d = S_EXEC;
        else if (Opcode == OP_ADDI)             state_d = S_ADDIEX;
        else if (Opcode == OP_BEQ)              state_d = S_BRANCH;
        else if (BNE_EN && Opcode == OP_BNE)    state_d = S_BRANCH;
        else if (Opcode == OP_J)                state_d = S_JUMP;
        else                                    state_d = S_TRAP;
      end
      S_MEMADR: state_d = (op_q == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  if (MemReady) state_d = S_MEMWB;
      S_MEMWB:  state_d = S_FETCH;
      S_MEMWR:  if (MemReady) state_d = S_FETCH;
      S_EXEC:   state_d = S_ALUWB;
      S_ALUWB:  state_d = S_FETCH;
      S_ADDIEX: state_d = S_ADDIWB;
      S_ADDIWB: state_d = S_FETCH;
      S_BRANCH: state_d = S_FETCH;
      S_JUMP:   state_d = S_FETCH;
      S_TRAP:   state_d = S_TRAP;
      default:  state_d = S_FETCH;
    endcase
    ne_d = BNE_EN & (op_d == OP_BNE);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_FETCH;
      op_q    <= '0;
      ctl_q   <= decode_ctl(S_FETCH, 1'b0);
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      ctl_q   <= decode_ctl(state_d, ne_d);
    end
  end

  // Write enables are gated by RST combinationally so a pending write drops in the reset cycle.
  assign IRWE      = ctl_q.fetch & MemReady & ~RST;
  assign PCWE      = (ctl_q.pcwe | (ctl_q.fetch & MemReady)) & ~RST;
  assign Branch    = ctl_q.branch & ~RST;
  assign DMWE      = ctl_q.dmwe & ~RST;
  assign RFWE      = ctl_q.rfwe & ~RST;
  assign IorD      = ctl_q.iord;
  assign MtoRFSel  = ctl_q.mtorf;
  assign RFDSel    = ctl_q.rfdsel;
  assign ALUIn1Sel = ctl_q.alu1;
  assign ALUIn2Sel = ctl_q.alu2;
  assign ALUOp     = ctl_q.aluop;
  assign PCSrc     = ctl_q.pcsrc;
  assign BranchNE  = ctl_q.bne;
  assign Illegal   = ctl_q.illegal;
  assign State     = state_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed scoreboard bench for mc_control_fsm; honours MC_CTRL_BNE_EN when defined.
module tb_mc_control_fsm;

  logic       CLK, RST, MemReady;
  logic [5:0] Opcode;
  logic       IRWE, PCWE, Branch, IorD, MtoRFSel, DMWE, RFWE, RFDSel, ALUIn1Sel;
  logic [1:0] ALUIn2Sel, ALUOp, PCSrc;
  logic       BranchNE, Illegal;
  logic [3:0] State;
  logic [16:0] outs_w;

  typedef struct {
    logic [3:0]  st;
    logic [16:0] outs;
    int          step;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   step_no = 0;

  mc_control_fsm #(.OPW(6)) dut (
    .CLK(CLK), .RST(RST), .Opcode(Opcode), .MemReady(MemReady),
    .IRWE(IRWE), .PCWE(PCWE), .Branch(Branch), .IorD(IorD), .MtoRFSel(MtoRFSel),
    .DMWE(DMWE), .RFWE(RFWE), .RFDSel(RFDSel), .ALUIn1Sel(ALUIn1Sel),
    .ALUIn2Sel(ALUIn2Sel), .ALUOp(ALUOp), .PCSrc(PCSrc), .BranchNE(BranchNE),
    .Illegal(Illegal), .State(State)
  );

  assign outs_w = {IRWE, PCWE, Branch, IorD, MtoRFSel, DMWE, RFWE, RFDSel, ALUIn1Sel,
                   ALUIn2Sel, ALUOp, PCSrc, BranchNE, Illegal};

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Output table per state, written from the controller's state description.
  function automatic logic [16:0] spec_outs(input logic [3:0] st, input logic mr,
                                            input logic rst, input logic bne);
    logic irwe, pcwe, br, iord, mtor, dmwe, rfwe, rfds, a1, bn, ill;
    logic [1:0] a2, aop, pcs;
    {irwe, pcwe, br, iord, mtor, dmwe, rfwe, rfds, a1, bn, ill} = '0;
    a2 = 2'b00; aop = 2'b00; pcs = 2'b00;
    case (st)
      4'd0:  begin irwe = mr; pcwe = mr; a2 = 2'b01; end
      4'd1:  a2 = 2'b10;
      4'd2:  begin a1 = 1'b1; a2 = 2'b10; end
      4'd3:  iord = 1'b1;
      4'd4:  begin rfwe = 1'b1; mtor = 1'b1; end
      4'd5:  begin iord = 1'b1; dmwe = 1'b1; end
      4'd6:  begin a1 = 1'b1; aop = 2'b11; end
      4'd7:  begin rfwe = 1'b1; rfds = 1'b1; end
      4'd8:  begin a1 = 1'b1; aop = 2'b01; br = 1'b1; pcs = 2'b01; bn = bne; end
      4'd9:  begin a1 = 1'b1; a2 = 2'b10; end
      4'd10: rfwe = 1'b1;
      4'd11: begin pcwe = 1'b1; pcs = 2'b10; end
      4'd12: ill = 1'b1;
      default: ;
    endcase
    if (rst) {irwe, pcwe, br, dmwe, rfwe} = '0;
    return {irwe, pcwe, br, iord, mtor, dmwe, rfwe, rfds, a1, a2, aop, pcs, bn, ill};
  endfunction

  task automatic check_head();
    exp_t e;
    if (sb.size() == 0) begin
      n_tests++;
      n_fail++;
      $error("FAIL scoreboard_empty observed=0 required=1");
      return;
    end
    e = sb.pop_front();
    n_tests++;
    assert (State === e.st) else begin
      n_fail++;
      $error("FAIL state step=%0d observed=%0d required=%0d", e.step, State, e.st);
    end
    n_tests++;
    assert (outs_w === e.outs) else begin
      n_fail++;
      $error("FAIL outputs step=%0d state=%0d observed=%b required=%b", e.step, e.st, outs_w, e.outs);
    end
  endtask

  // One clock cycle: drive inputs, record expectation, compare at the falling edge.
  task automatic cyc(input logic [3:0] st, input logic mr, input logic rst, input logic bne);
    exp_t e;
    MemReady = mr;
    RST      = rst;
    e.st     = st;
    e.outs   = spec_outs(st, mr, rst, bne);
    e.step   = step_no++;
    sb.push_back(e);
    @(negedge CLK);
    check_head();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RST = 1'b1; MemReady = 1'b0; Opcode = 6'd0;
    @(posedge CLK);
    #1;
    cyc(4'd0, 1'b1, 1'b1, 1'b0);
    cyc(4'd0, 1'b1, 1'b1, 1'b0);

    Opcode = 6'd0;                         // R-type: 0,1,6,7
    cyc(4'd0, 1'b1, 1'b0, 1'b0);
    cyc(4'd1, 1'b1, 1'b0, 1'b0);
    cyc(4'd6, 1'b1, 1'b0, 1'b0);
    cyc(4'd7, 1'b1, 1'b0, 1'b0);

    Opcode = 6'd35;                        // lw with 3 wait states in MEMRD
    cyc(4'd0, 1'b1, 1'b0, 1'b0);
    cyc(4'd1, 1'b1, 1'b0, 1'b0);
    cyc(4'd2, 1'b1, 1'b0, 1'b0);
    cyc(4'd3, 1'b0, 1'b0, 1'b0);
    cyc(4'd3, 1'b0, 1'b0, 1'b0);
    cyc(4'd3, 1'b0, 1'b0, 1'b0);
    cyc(4'd3, 1'b1, 1'b0, 1'b0);
    cyc(4'd4, 1'b1, 1'b0, 1'b0);

    Opcode = 6'd43;                        // sw with fetch stall and 2 wait states in MEMWR
    cyc(4'd0, 1'b0, 1'b0, 1'b0);
    cyc(4'd0, 1'b0, 1'b0, 1'b0);
    cyc(4'd0, 1'b1, 1'b0, 1'b0);
    cyc(4'd1, 1'b0, 1'b0, 1'b0);
    cyc(4'd2, 1'b0, 1'b0, 1'b0);
    cyc(4'd5, 1'b0, 1'b0, 1'b0);
    cyc(4'd5, 1'b0, 1'b0, 1'b0);
    cyc(4'd5, 1'b1, 1'b0, 1'b0);

    Opcode = 6'd8;                         // addi
    cyc(4'd0, 1'b1, 1'b0, 1'b0);
    cyc(4'd1, 1'b1, 1'b0, 1'b0);
    cyc(4'd9, 1'b0, 1'b0, 1'b0);
    cyc(4'd10, 1'b0, 1'b0, 1'b0);

    Opcode = 6'd4;                         // beq
    cyc(4'd0, 1'b1, 1'b0, 1'b0);
    cyc(4'd1, 1'b1, 1'b0, 1'b0);
    cyc(4'd8, 1'b1, 1'b0, 1'b0);

    Opcode = 6'd2;                         // j
    cyc(4'd0, 1'b1, 1'b0, 1'b0);
    cyc(4'd1, 1'b1, 1'b0, 1'b0);
    cyc(4'd11, 1'b0, 1'b0, 1'b0);

    Opcode = 6'h3F;                        // illegal -> sticky trap
    cyc(4'd0, 1'b1, 1'b0, 1'b0);
    cyc(4'd1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) cyc(4'd12, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
    cyc(4'd12, 1'b1, 1'b1, 1'b0);
    cyc(4'd0, 1'b0, 1'b0, 1'b0);

    Opcode = 6'd5;                         // bne
    cyc(4'd0, 1'b1, 1'b0, 1'b0);
    cyc(4'd1, 1'b1, 1'b0, 1'b0);
`ifdef MC_CTRL_BNE_EN
    cyc(4'd8, 1'b1, 1'b0, 1'b1);
`else
    cyc(4'd12, 1'b1, 1'b0, 1'b0);
    cyc(4'd12, 1'b1, 1'b1, 1'b0);
`endif

    Opcode = 6'd43;                        // reset while a store is pending
    cyc(4'd0, 1'b1, 1'b0, 1'b0);
    cyc(4'd1, 1'b1, 1'b0, 1'b0);
    cyc(4'd2, 1'b1, 1'b0, 1'b0);
    cyc(4'd5, 1'b0, 1'b0, 1'b0);
    cyc(4'd5, 1'b0, 1'b1, 1'b0);
    cyc(4'd0, 1'b0, 1'b0, 1'b0);

    Opcode = 6'd0;                         // reset mid R-type aborts it
    cyc(4'd0, 1'b1, 1'b0, 1'b0);
    cyc(4'd1, 1'b1, 1'b0, 1'b0);
    cyc(4'd6, 1'b1, 1'b1, 1'b0);
    cyc(4'd0, 1'b1, 1'b0, 1'b0);

    n_tests++;
    assert (sb.size() == 0) else begin
      n_fail++;
      $error("FAIL scoreboard_drain observed=%0d required=0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mc_control_fsm.md
# mc_control_fsm

Multicycle main controller for the MIPS datapath: replaces the single-cycle opcode decoder with a Moore state machine that sequences fetch, decode, execute, memory and write-back over several cycles, sharing one ALU and one memory port. It sits between the instruction register's opcode field and all datapath enables and selects. It adds memory wait-state handshaking, parametrised opcode encodings and a sticky illegal-opcode trap.

## Interface
- OPW, 6: opcode field width.
- OP_RTYPE / OP_LW / OP_SW / OP_ADDI / OP_BEQ / OP_J, 0 / 35 / 43 / 8 / 4 / 2: opcode encodings (OPW bits each).
- OP_BNE, 5: bne encoding (used only with the macro below).
- CLK  in  1  clock, all state updates on rising edge.
- RST  in  1  synchronous, active-high reset.
- Opcode  in  OPW  instruction register opcode field, sampled in DECODE.
- MemReady  in  1  memory completes the current access this cycle.
- IRWE, PCWE, Branch, IorD, MtoRFSel, DMWE, RFWE, RFDSel, ALUIn1Sel  out  1 each  datapath enables/selects.
- ALUIn2Sel  out  2  00 RFRD2, 01 constant 1, 10 Simm.
- ALUOp  out  2  00 add, 01 sub, 11 use funct.
- PCSrc  out  2  00 ALUResult, 01 ALUOut, 10 JTA.
- BranchNE  out  1  invert the zero test (0 unless macro set).
- Illegal  out  1  sticky trap flag.
- State  out  4  current state code, for debug.

## Operation
- State codes: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, ALUWB 7, BRANCH 8, ADDIEX 9, ADDIWB 10, JUMP 11, TRAP 12. Codes 13–15 are unreachable; if entered, the next state is FETCH.
- Any output not listed for a state is 0. Outputs never drive Z or X.
- FETCH: IorD=0, ALUIn1Sel=0, ALUIn2Sel=01, ALUOp=00, PCSrc=00. IRWE and PCWE equal MemReady. Stays in FETCH until MemReady=1, then goes to DECODE.
- DECODE: ALUIn1Sel=0, ALUIn2Sel=10, ALUOp=00 (precomputes the branch target). Next state by Opcode:
  - lw/sw → MEMADR
  - R-type → EXEC
  - addi → ADDIEX
  - beq → BRANCH
  - j → JUMP
  - anything else → TRAP
- MEMADR: ALUIn1Sel=1, ALUIn2Sel=10, ALUOp=00. Goes to MEMRD for lw, MEMWR for sw. Opcode is held stable by the IR.
- MEMRD: IorD=1. Waits for MemReady, then goes to MEMWB.
- MEMWB: RFWE=1, MtoRFSel=1, RFDSel=0. Goes to FETCH.
- MEMWR: IorD=1, DMWE=1, held every cycle until MemReady=1. Goes to FETCH on that cycle.
- EXEC: ALUIn1Sel=1, ALUIn2Sel=00, ALUOp=11. Goes to ALUWB.
- ALUWB: RFWE=1, RFDSel=1, MtoRFSel=0. Goes to FETCH.
- ADDIEX: ALUIn1Sel=1, ALUIn2Sel=10, ALUOp=00. Goes to ADDIWB.
- ADDIWB: RFWE=1, RFDSel=0, MtoRFSel=0. Goes to FETCH.
- BRANCH: ALUIn1Sel=1, ALUIn2Sel=00, ALUOp=01, Branch=1, PCSrc=01. Goes to FETCH.
- JUMP: PCWE=1, PCSrc=10. Goes to FETCH.
- TRAP: Illegal=1, all enables 0. Stays in TRAP until RST.

## Timing
- On the RST=1 edge: State←FETCH and Illegal←0.
- While RST=1, all write enables (IRWE, PCWE, DMWE, RFWE, Branch) are forced to 0, regardless of MemReady.
- Reset mid-operation aborts the instruction. A pending DMWE drops in the same cycle that RST is high.
- Outputs other than IRWE/PCWE in FETCH are pure functions of State. The FETCH enables are combinational on MemReady.
- Cycle counts with MemReady tied high:
  - R-type: 4
  - addi: 4
  - lw: 5
  - sw: 4
  - beq: 3
  - j: 3
  - illegal: 2 cycles, then TRAP forever
- Each MemReady=0 cycle in FETCH, MEMRD or MEMWR adds exactly one cycle. No timeout.
- MemReady is ignored in all other states.

## Configuration
- MC_CTRL_BNE_EN defined:
  - DECODE sends OP_BNE to BRANCH.
  - In BRANCH, BranchNE=1 when the latched opcode is bne, 0 for beq. The opcode is latched in DECODE.
- Not defined:
  - OP_BNE decodes as illegal → TRAP.
  - BranchNE is tied to 0.

## Test plan
- Reset with RST=1 for 2 cycles, then R-type opcode 0, MemReady=1 → State sequence 0,1,6,7,0. RFWE=1 only in state 7, with RFDSel=1.
- lw opcode 35, MemReady low for 3 cycles in MEMRD → sequence 0,1,2,3,3,3,3,4,0. IorD=1 throughout state 3. RFWE=1 with MtoRFSel=1 in state 4.
- sw opcode 43, MemReady low for 2 cycles in MEMWR → DMWE=1 for exactly 3 cycles, returns to FETCH, RFWE never asserts.
- Opcode 6'h3F in DECODE → TRAP, Illegal=1 held for 20 cycles. RST pulse → State=0, Illegal=0.
- Opcode 5 → with MC_CTRL_BNE_EN: BRANCH state with BranchNE=1. Without it: TRAP.
- RST asserted while in MEMWR with MemReady=0 → DMWE=0 in that cycle, State=0 on the next edge.
